// File: rtl/comparador_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serial_pkg
// Purpose  : PQ codes, FSM states and the 1-bit comparison cell rule shared by
//            the serial magnitude comparator and its slice network.
// Revision : 1.0 - initial release
// ============================================================================
package comparador_serial_pkg;

    // PQ state carried between bits: P = A>B, Q = A<B; 2'b11 never occurs.
    localparam logic [1:0] PQ_EQ = 2'b00;
    localparam logic [1:0] PQ_GT = 2'b10;
    localparam logic [1:0] PQ_LT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // A sign bit weighs negatively, so the roles of A and B swap on that bit.
    function automatic logic [1:0] pq_cell(
        input logic [1:0] pq_in,
        input logic       a_bit,
        input logic       b_bit,
        input logic       sign_bit
    );
        logic [1:0] pq;
        pq = pq_in;
        if ((pq_in == PQ_EQ) && (a_bit != b_bit)) begin
            pq = (a_bit ^ sign_bit) ? PQ_GT : PQ_LT;
        end
        return pq;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comparador_serial_celda.sv
`default_nettype none
// ============================================================================
// Module   : celda_comparacion
// Purpose  : Combinational K-bit slice of the MSB-first comparator; a chain of
//            1-bit cells that refines the incoming PQ state.
// Revision : 1.0 - initial release
// ============================================================================
module celda_comparacion
    import comparador_serial_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [K-1:0] i_a_slice,
    input  logic [K-1:0] i_b_slice,
    input  logic [1:0]   i_pq_in,
    input  logic         i_msb_signed,
    output logic [1:0]   o_pq_out
);

    // w_pq[K] enters at the slice MSB, w_pq[0] leaves after the slice LSB.
    logic [K:0][1:0] w_pq;

    assign w_pq[K] = i_pq_in;

    generate
        for (genvar i = 0; i < K; i++) begin : g_chain
            assign w_pq[i] = pq_cell(w_pq[i+1], i_a_slice[i], i_b_slice[i],
                                     (i == K - 1) ? i_msb_signed : 1'b0);
        end
    endgenerate

    assign o_pq_out = w_pq[0];

endmodule
`default_nettype wire

// File: rtl/comparador_serial.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serial
// Purpose  : Sequential MSB-first magnitude comparator, K bits per clock, with
//            signed mode, early termination, start/done handshake and abort.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_serial
    import comparador_serial_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_signed_mode,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_gt,
    output logic         o_lt,
    output logic         o_eq
);

    localparam int K_SAFE = (K < 1) ? 1 : K;
    localparam int NS     = N / K_SAFE;
    localparam int IW     = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    generate
        if ((N < 2) || (K < 1) || (K > N) || ((N % K_SAFE) != 0)) begin : g_param_check
            $error("comparador_serial: illegal N/K combination");
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_signed;
    logic [IW-1:0] r_idx;
    logic [1:0]    r_pq;
    logic          r_gt;
    logic          r_lt;
    logic          r_eq;

    logic [K-1:0]  w_a_slices [NS];
    logic [K-1:0]  w_b_slices [NS];
    logic [K-1:0]  w_a_slice;
    logic [K-1:0]  w_b_slice;
    logic [1:0]    w_pq_out;
    logic          w_msb_signed;
    logic          w_last;
    logic          w_accept;
    logic          w_finish;

    // Slice s covers bits N-1-s*K down to N-K-s*K, MSB slice first.
    generate
        for (genvar s = 0; s < NS; s++) begin : g_slices
            assign w_a_slices[s] = r_a[N-1-s*K -: K];
            assign w_b_slices[s] = r_b[N-1-s*K -: K];
        end
    endgenerate

    assign w_a_slice    = w_a_slices[r_idx];
    assign w_b_slice    = w_b_slices[r_idx];
    assign w_msb_signed = r_signed & (r_idx == '0);
    assign w_last       = (r_idx == LAST_IDX);

    celda_comparacion #(
        .K (K)
    ) u_celda (
        .i_a_slice    (w_a_slice),
        .i_b_slice    (w_b_slice),
        .i_pq_in      (r_pq),
        .i_msb_signed (w_msb_signed),
        .o_pq_out     (w_pq_out)
    );

    // Abort takes priority over both accepting and finishing.
    assign w_accept = (r_state == ST_IDLE) & i_start & ~i_abort;
    assign w_finish = (r_state == ST_COMPARE) & ~i_abort &
                      ((w_pq_out != PQ_EQ) | w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_finish) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_pq     <= PQ_EQ;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_signed <= i_signed_mode;
            r_idx    <= '0;
            r_pq     <= PQ_EQ;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else if ((r_state != ST_IDLE) && i_abort) begin
            r_gt <= 1'b0;
            r_lt <= 1'b0;
            r_eq <= 1'b0;
        end else if (r_state == ST_COMPARE) begin
            r_pq <= w_pq_out;
            if (w_finish) begin
                r_gt <= (w_pq_out == PQ_GT);
                r_lt <= (w_pq_out == PQ_LT);
                r_eq <= (w_pq_out == PQ_EQ);
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign o_busy = (r_state == ST_COMPARE);
    assign o_done = (r_state == ST_DONE) & ~i_abort;
    assign o_gt   = r_gt;
    assign o_lt   = r_lt;
    assign o_eq   = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_comparador_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparador_serial
// Purpose  : Self-checking bench for comparador_serial (K=1 and K=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparador_serial;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         sgn;
        bit         k4;
        logic [2:0] res;   // {gt, lt, eq}
        int         lat;
    } vec_t;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sgn = 1'b0;
    logic       use4 = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic bz1, dn1, gt1, lt1, eq1;
    logic bz4, dn4, gt4, lt4, eq4;
    logic busy, done, gt, lt, eq;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    comparador_serial #(.N(8), .K(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start & ~use4),
        .i_abort       (abort & ~use4),
        .i_signed_mode (sgn),
        .i_a           (a),
        .i_b           (b),
        .o_busy        (bz1),
        .o_done        (dn1),
        .o_gt          (gt1),
        .o_lt          (lt1),
        .o_eq          (eq1)
    );

    comparador_serial #(.N(8), .K(4)) dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start & use4),
        .i_abort       (abort & use4),
        .i_signed_mode (sgn),
        .i_a           (a),
        .i_b           (b),
        .o_busy        (bz4),
        .o_done        (dn4),
        .o_gt          (gt4),
        .o_lt          (lt4),
        .o_eq          (eq4)
    );

    assign busy = use4 ? bz4 : bz1;
    assign done = use4 ? dn4 : dn1;
    assign gt   = use4 ? gt4 : gt1;
    assign lt   = use4 ? lt4 : lt1;
    assign eq   = use4 ? eq4 : eq1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [2:0] model_res(input logic [7:0] va, input logic [7:0] vb, input bit vs);
        logic g, l;
        if (vs) begin
            g = $signed(va) > $signed(vb);
            l = $signed(va) < $signed(vb);
        end else begin
            g = va > vb;
            l = va < vb;
        end
        return {g, l, (va == vb)};
    endfunction

    function automatic int model_lat(input logic [7:0] va, input logic [7:0] vb, input int k);
        for (int i = 0; i < 8; i++) begin
            if (va[7-i] != vb[7-i]) return i / k + 2;
        end
        return 8 / k + 1;
    endfunction

    // One transaction: expectation goes to the scoreboard at start, popped at done.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input bit vs,
                          input bit vk4, input logic [2:0] res, input int lat, input bit repulse);
        exp_t e;
        int   done_lat;
        int   busy_cnt;
        bit   seen;
        bit   extra;
        e.res = res;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        use4 = vk4;
        #1;
        chk("idle_before_start", {30'd0, busy, done}, 32'd0);
        a = va; b = vb; sgn = vs; start = 1'b1;
        seen = 1'b0; done_lat = 0; busy_cnt = 0;
        for (int cnt = 1; cnt <= 40 && !seen; cnt++) begin
            @(posedge clk); #1;
            start = repulse && (cnt == 1);
            if (cnt == 1) begin
                chk("accept_busy_cleared", {28'd0, busy, gt, lt, eq}, 32'h8);
                a = ~va; b = vb ^ 8'h5A; sgn = ~vs;
            end
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                done_lat = cnt;
            end
        end
        start = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("busy_low_at_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("result_gt_lt_eq", {29'd0, gt, lt, eq}, {29'd0, e.res});
                chk("latency", done_lat, e.lat);
                chk("busy_cycles", busy_cnt, e.lat - 1);
            end
        end
        if (repulse) begin
            extra = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (busy || done) extra = 1'b1;
            end
            chk("restart_while_busy_ignored", {31'd0, extra}, 32'd0);
        end
    endtask

    initial begin
        bit         flag;
        logic [7:0] ra, rb, one;
        bit         rs, rk;

        vecs[0]  = '{8'h80, 8'h7F, 1'b0, 1'b0, 3'b100, 2};
        vecs[1]  = '{8'hA5, 8'hA5, 1'b0, 1'b0, 3'b001, 9};
        vecs[2]  = '{8'h80, 8'h01, 1'b1, 1'b0, 3'b010, 2};
        vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b0, 3'b100, 2};
        vecs[4]  = '{8'h01, 8'h02, 1'b0, 1'b0, 3'b010, 8};
        vecs[5]  = '{8'h34, 8'h35, 1'b0, 1'b1, 3'b010, 3};
        vecs[6]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 3'b010, 2};
        vecs[7]  = '{8'h7F, 8'h80, 1'b1, 1'b0, 3'b100, 2};
        vecs[8]  = '{8'h00, 8'h01, 1'b0, 1'b0, 3'b010, 9};
        vecs[9]  = '{8'hFE, 8'hFF, 1'b1, 1'b0, 3'b010, 9};
        vecs[10] = '{8'hA5, 8'hA5, 1'b1, 1'b1, 3'b001, 3};
        vecs[11] = '{8'hC3, 8'hC0, 1'b0, 1'b1, 3'b100, 3};
        vecs[12] = '{8'h90, 8'h20, 1'b1, 1'b1, 3'b010, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state_k1", {27'd0, bz1, dn1, gt1, lt1, eq1}, 32'd0);
        chk("reset_state_k4", {27'd0, bz4, dn4, gt4, lt4, eq4}, 32'd0);
        rst_n = 1'b1;

        // Consecutive table entries also exercise back-to-back starts.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].k4,
                   vecs[i].res, vecs[i].lat, (i == 5));
        end

        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom);
            one = 8'h01;
            rb  = (i % 3 == 0) ? (ra ^ (one << (i % 8))) : 8'($urandom);
            rs  = i[0];
            rk  = i[1];
            run_op(ra, rb, rs, rk, model_res(ra, rb, rs), model_lat(ra, rb, rk ? 4 : 1), 1'b0);
        end

        // Result hold after done, then clear on the next accepted start.
        run_op(8'hA5, 8'hA5, 1'b0, 1'b0, 3'b001, 9, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("eq_held_after_done", {29'd0, gt, lt, eq}, 32'h1);

        // Abort on the third COMPARE cycle.
        @(posedge clk); #1;
        use4 = 1'b0; a = 8'h00; b = 8'h00; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_before_abort", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_to_idle", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        flag = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) flag = 1'b1;
        end
        chk("abort_no_done", {31'd0, flag}, 32'd0);

        // Abort and start together in IDLE: nothing is accepted, old result kept.
        run_op(8'hF0, 8'h0F, 1'b0, 1'b0, 3'b100, 2, 1'b0);
        @(posedge clk); #1;
        a = 8'h00; b = 8'h01; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", {30'd0, busy, gt}, 32'h1);

        // Asynchronous reset in the middle of a compare.
        @(posedge clk); #1;
        a = 8'h03; b = 8'h02; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) flag = 1'b1;
        end
        chk("reset_no_done", {31'd0, flag}, 32'd0);

        // Operation after reset still works.
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 3'b010, 8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
